fc_seq_ctrl: RTL
================

Name: fc_seq_ctrl

Overview:
- Sequencer for the FC layer datapath; sits between the AXIS slave port and the MAC/feature-buffer datapath inside the FC module.
- After a start pulse it walks three phases:
  - feature load;
  - per-neuron bias plus weight streaming, with the matching feature-buffer read address;
  - result emission on an output handshake.
- Drives busy/done/err toward the APB register block.

Parameters:
IN_AW, 10, feature buffer address width; max in_len = 2^IN_AW-1 words (4 packed int8 per word)
OUT_W, 8, output-neuron counter width; max out_len = 2^OUT_W-1
MAC_LAT, 2, cycles from last w_valid beat to acc valid (1..7)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle start pulse from the APB register block
in_len  in  IN_AW  feature words per input vector
out_len  in  OUT_W  number of output neurons
busy  out  1  high from accepted start until done
done  out  1  level; high in DONE until next accepted start
err  out  1  sticky TLAST protocol error, cleared on accepted start
s_valid  in  1  AXIS TVALID
s_ready  out  1  AXIS TREADY
s_last  in  1  AXIS TLAST
feat_we  out  1  write current s_data word to feature buffer
bias_we  out  1  load current s_data word into accumulator as bias
w_valid  out  1  current s_data word is a weight; MAC enable
feat_addr  out  IN_AW  feature buffer write address (LOAD_FEAT) or read address (LOAD_W)
acc  in  32  signed accumulator value from datapath
m_valid  out  1  result valid to output stage
m_ready  in  1  output stage ready
m_last  out  1  high with m_valid for final neuron
out_idx  out  OUT_W  index of the neuron currently presented

Behaviour:
- Reset (async, rstn=0): state IDLE. All outputs 0, all counters 0, err 0.
- Beat = s_valid && s_ready.
- s_ready is 1 only in LOAD_FEAT, LOAD_BIAS and LOAD_W.
- feat_we, bias_we and w_valid equal beat qualified by the current state (combinational).
- in_len/out_len are latched on an accepted start.
- FSM: IDLE -> LOAD_FEAT -> {LOAD_BIAS -> LOAD_W -> WAIT -> EMIT} x out_len -> DONE.
- IDLE/DONE + start:
  - latch lengths, clear err/done, set busy, feat_addr=0;
  - if in_len==0 or out_len==0, go directly to DONE next cycle; no beats accepted.
- LOAD_FEAT:
  - each beat writes feat_addr, then increments it;
  - on beat in_len-1 (the last word): feat_addr<=0, go to LOAD_BIAS.
- LOAD_BIAS: one beat (bias_we) -> LOAD_W, feat_addr=0.
- LOAD_W:
  - each beat asserts w_valid with feat_addr = index of that weight; increment;
  - after in_len beats, go to WAIT.
- WAIT: count MAC_LAT cycles, then go to EMIT.
- EMIT:
  - m_valid=1, out_idx = neuron index;
  - m_last = (out_idx==out_len-1);
  - hold until m_ready;
  - on handshake: if last neuron go to DONE, else neuron+1 and go to LOAD_BIAS.
- DONE: done=1, busy=0; stays until next start.
- TLAST check:
  - s_last is required on the last LOAD_FEAT beat and on the last LOAD_W beat of the final neuron; it must be 0 on all other beats.
  - On mismatch: err<=1, state -> DONE the next cycle; the remainder of the frame is not accepted (s_ready=0).
- start while busy is ignored.
- m_ready while not in EMIT is ignored.
- Mid-operation reset aborts immediately to reset values.
- Latency, no backpressure, in_len=N, out_len=M: N + M*(1+N+MAC_LAT+1) cycles from start to done.

Optional Feature:
- Macro FC_SEQ_ARGMAX_EN.
- When defined:
  - extra outputs max_index [OUT_W] and max_value [32], reset 0;
  - at each EMIT handshake, if first neuron or acc > max_value (signed, strict), capture acc and out_idx;
  - ties keep the earlier index;
  - values are valid when done=1 and held until next accepted start, which clears them.
- When undefined: ports and logic are absent.

Decomposition:
- Shared package fc_pkg:
  - state enum (IDLE, LOAD_FEAT, LOAD_BIAS, LOAD_W, WAIT, EMIT, DONE);
  - ACC_W=32 constant.
- Natural sub-module: fc_argmax_tracker (compare/capture logic), instantiated only under FC_SEQ_ARGMAX_EN.

Test Plan:
- in_len=3, out_len=2, s_valid/m_ready always 1:
  - exactly 3 feat_we, then per neuron 1 bias_we + 3 w_valid with feat_addr 0,1,2;
  - m_last on out_idx=1; done after 3+2*(1+3+2+1)=17 cycles.
- m_ready low for 5 cycles in EMIT → m_valid held, out_idx stable, s_ready=0 throughout; proceeds on m_ready.
- s_last asserted on feature beat 1 of in_len=3 → err=1, DONE next cycle, s_ready=0 afterward; next start clears err.
- in_len=0 → done=1 one cycle after start, zero beats, m_valid never asserted.
- start pulsed mid-LOAD_W; rstn dropped in WAIT → first start ignored; reset forces all outputs 0/IDLE asynchronously.
- FC_SEQ_ARGMAX_EN, acc sequence -5, 7, 7, -1 over 4 neurons → max_index=1, max_value=7 at done.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types for the FC layer sequencer: FSM state encoding and accumulator width.
`timescale 1ns/1ps
package fc_pkg;

  localparam int ACC_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_FEAT,
    LOAD_BIAS,
    LOAD_W,
    WAIT,
    EMIT,
    DONE
  } fc_state_t;

endpackage

// File: rtl/fc_argmax_tracker.sv
// Running signed arg-max over emitted neuron results; ties keep the earlier index.
`timescale 1ns/1ps
module fc_argmax_tracker
  import fc_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clear,
  input  logic                    capture,
  input  logic                    first,
  input  logic [OUT_W-1:0]        idx,
  input  logic signed [ACC_W-1:0] value,
  output logic [OUT_W-1:0]        max_index,
  output logic signed [ACC_W-1:0] max_value
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      max_index <= '0;
      max_value <= '0;
    end else if (clear) begin
      max_index <= '0;
      max_value <= '0;
    end else if (capture && (first || (value > max_value))) begin
      max_index <= idx;
      max_value <= value;
    end
  end

endmodule

// File: rtl/fc_seq_ctrl.sv
// FC layer sequencer: feature load, per-neuron bias/weight streaming, result emission.
// Optional arg-max outputs are built when FC_SEQ_ARGMAX_EN is defined.
`timescale 1ns/1ps
module fc_seq_ctrl
  import fc_pkg::*;
#(
  parameter int IN_AW   = 10,
  parameter int OUT_W   = 8,
  parameter int MAC_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [IN_AW-1:0]        in_len,
  input  logic [OUT_W-1:0]        out_len,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    s_last,
  output logic                    feat_we,
  output logic                    bias_we,
  output logic                    w_valid,
  output logic [IN_AW-1:0]        feat_addr,
  input  logic signed [ACC_W-1:0] acc,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
`ifdef FC_SEQ_ARGMAX_EN
  output logic [OUT_W-1:0]        max_index,
  output logic signed [ACC_W-1:0] max_value,
`endif
  output logic [OUT_W-1:0]        out_idx
);

  localparam logic [2:0] WAIT_LAST = 3'(MAC_LAT - 1);

  fc_state_t        state;
  logic [IN_AW-1:0] in_len_q;
  logic [OUT_W-1:0] out_len_q;
  logic [OUT_W-1:0] neuron;
  logic [2:0]       wait_cnt;
  logic             beat;
  logic             word_last;
  logic             last_neuron;
  logic             last_exp;
  logic             last_err;
  logic             start_acc;
  logic             emit_hs;

  assign s_ready     = (state == LOAD_FEAT) || (state == LOAD_BIAS) || (state == LOAD_W);
  assign beat        = s_valid && s_ready;
  assign feat_we     = beat && (state == LOAD_FEAT);
  assign bias_we     = beat && (state == LOAD_BIAS);
  assign w_valid     = beat && (state == LOAD_W);
  assign word_last   = (feat_addr == in_len_q - IN_AW'(1));
  assign last_neuron = (neuron == out_len_q - OUT_W'(1));
  assign m_valid     = (state == EMIT);
  assign m_last      = m_valid && last_neuron;
  assign out_idx     = neuron;
  assign emit_hs     = m_valid && m_ready;
  assign start_acc   = start && ((state == IDLE) || (state == DONE));

  // TLAST marks the end of the feature vector and the end of the whole weight frame only.
  assign last_exp = ((state == LOAD_FEAT) && word_last) ||
                    ((state == LOAD_W) && word_last && last_neuron);
  assign last_err = beat && (s_last != last_exp);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      in_len_q  <= '0;
      out_len_q <= '0;
      neuron    <= '0;
      wait_cnt  <= '0;
      feat_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else if (last_err) begin
      state <= DONE;
      err   <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            in_len_q  <= in_len;
            out_len_q <= out_len;
            err       <= 1'b0;
            feat_addr <= '0;
            neuron    <= '0;
            wait_cnt  <= '0;
            if ((in_len == '0) || (out_len == '0)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= LOAD_FEAT;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        LOAD_FEAT: begin
          if (beat) begin
            if (word_last) begin
              feat_addr <= '0;
              state     <= LOAD_BIAS;
            end else begin
              feat_addr <= feat_addr + IN_AW'(1);
            end
          end
        end
        LOAD_BIAS: begin
          if (beat) begin
            feat_addr <= '0;
            state     <= LOAD_W;
          end
        end
        LOAD_W: begin
          if (beat) begin
            if (word_last) begin
              feat_addr <= '0;
              wait_cnt  <= '0;
              state     <= WAIT;
            end else begin
              feat_addr <= feat_addr + IN_AW'(1);
            end
          end
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= EMIT;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        EMIT: begin
          if (m_ready) begin
            if (last_neuron) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              neuron <= neuron + OUT_W'(1);
              state  <= LOAD_BIAS;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FC_SEQ_ARGMAX_EN
  fc_argmax_tracker #(
    .OUT_W(OUT_W)
  ) u_argmax (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (start_acc),
    .capture  (emit_hs),
    .first    (neuron == '0),
    .idx      (neuron),
    .value    (acc),
    .max_index(max_index),
    .max_value(max_value)
  );
`else
  // The accumulator is only observed by the arg-max tracker.
  logic unused_acc;
  assign unused_acc = ^{acc, start_acc, emit_hs};
`endif

endmodule
